// File: rtl/qei_speed_meter.sv
// Quadrature encoder decoder: 4x position count, per-window signed speed, error count.
// Optional glitch filter on the synchronised channels: define QEI_FILTER_EN.
module qei_speed_meter #(
  parameter int SAMPLE_CYCLES = 50000,
  parameter int SYNC_STAGES   = 2,
  parameter int DIR_INV       = 0,
  parameter int FILT_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clr_pos,
  input  logic               enc_a,
  input  logic               enc_b,
  output logic signed [31:0] speed,
  output logic               speed_valid,
  output logic signed [31:0] position,
  output logic               dir,
  output logic [7:0]         err_cnt
);

  localparam int CW = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CW-1:0] WIN_TC = CW'(SAMPLE_CYCLES - 1);
  localparam logic signed [32:0] ACC_MAX = 33'sh0_7FFF_FFFF;
  localparam logic signed [32:0] ACC_MIN = -ACC_MAX;

  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0]             raw_ab, cur_ab, prev_ab;
  logic                   init_done;
  logic [CW-1:0]          win_cnt;
  logic signed [31:0]     acc, acc_next, delta, step;
  logic signed [32:0]     acc_sum;
  logic                   illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
    end
  end

  assign raw_ab = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};

`ifdef QEI_FILTER_EN
  localparam int FW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [FW-1:0] FILT_LOAD = FW'(FILT_CYCLES - 1);

  logic [FW-1:0] fcnt [2];
  logic [1:0]    filt_ab;

  // Per channel: down-count while the input disagrees with the output; adopt at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_ab <= '0;
      fcnt[0] <= FILT_LOAD;
      fcnt[1] <= FILT_LOAD;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw_ab[i] == filt_ab[i]) begin
          fcnt[i] <= FILT_LOAD;
        end else if (fcnt[i] == '0) begin
          filt_ab[i] <= raw_ab[i];
          fcnt[i]    <= FILT_LOAD;
        end else begin
          fcnt[i] <= fcnt[i] - FW'(1);
        end
      end
    end
  end

  assign cur_ab = filt_ab;
`else
  assign cur_ab = raw_ab;
`endif

  always_comb begin
    step    = '0;
    illegal = 1'b0;
    if (en && init_done) begin
      case ({prev_ab, cur_ab})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step = 32'sd1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step = -32'sd1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: illegal = 1'b1;
        default:                                step = '0;
      endcase
    end
    delta = (DIR_INV != 0) ? -step : step;
  end

  // The window accumulator clamps symmetrically instead of wrapping.
  always_comb begin
    acc_sum = acc + delta;
    if (acc_sum > ACC_MAX)      acc_next = ACC_MAX[31:0];
    else if (acc_sum < ACC_MIN) acc_next = ACC_MIN[31:0];
    else                        acc_next = acc_sum[31:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed       <= '0;
      speed_valid <= 1'b0;
      position    <= '0;
      dir         <= 1'b0;
      err_cnt     <= '0;
      win_cnt     <= '0;
      acc         <= '0;
      prev_ab     <= '0;
      init_done   <= 1'b0;
    end else begin
      speed_valid <= 1'b0;
      if (!en) begin
        init_done <= 1'b0;
        win_cnt   <= '0;
        acc       <= '0;
      end else begin
        prev_ab   <= cur_ab;
        init_done <= 1'b1;
        if (win_cnt == WIN_TC) begin
          speed       <= acc_next;
          speed_valid <= 1'b1;
          acc         <= '0;
          win_cnt     <= '0;
        end else begin
          acc     <= acc_next;
          win_cnt <= win_cnt + CW'(1);
        end
      end
      if (clr_pos) position <= '0;
      else         position <= position + delta;
      if (delta != '0) dir <= (delta > 0);
      if (illegal && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_qei_speed_meter.sv
// Directed bench for qei_speed_meter: decode table plus multi-cycle window/boundary sequences.
module tb_qei_speed_meter;

  localparam int SC = 100;
`ifdef QEI_FILTER_EN
  localparam int LAT  = 11;
  localparam int HOLD = 10;
`else
  localparam int LAT  = 3;
  localparam int HOLD = 2;
`endif

  logic clk = 1'b0;
  logic rst, en, clr_pos, enc_a, enc_b;
  logic signed [31:0] speed, position, speed_i, position_i;
  logic speed_valid, speed_valid_i, dir, dir_i;
  logic [7:0] err_cnt, err_cnt_i;
  logic [1:0] ab;

  always #5 clk = ~clk;

  qei_speed_meter #(.SAMPLE_CYCLES(SC), .SYNC_STAGES(2), .DIR_INV(0), .FILT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr_pos(clr_pos), .enc_a(enc_a), .enc_b(enc_b),
    .speed(speed), .speed_valid(speed_valid), .position(position), .dir(dir), .err_cnt(err_cnt));

  qei_speed_meter #(.SAMPLE_CYCLES(SC), .SYNC_STAGES(2), .DIR_INV(1), .FILT_CYCLES(8)) u_inv (
    .clk(clk), .rst(rst), .en(en), .clr_pos(clr_pos), .enc_a(enc_a), .enc_b(enc_b),
    .speed(speed_i), .speed_valid(speed_valid_i), .position(position_i), .dir(dir_i),
    .err_cnt(err_cnt_i));

  typedef struct {
    logic [1:0] ab;
    int         dpos;
    int         derr;
    logic       dir;
  } vec_t;

  vec_t tbl [14];
  int   n_chk = 0;
  int   n_fail = 0;
  logic chk_speed = 1'b0;
  int   exp_speed = 0;
  int   strobes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_ab(input logic [1:0] v);
    ab    = v;
    enc_a = v[1];
    enc_b = v[0];
  endtask

  function automatic logic [1:0] fwd(input logic [1:0] x);
    case (x)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev(input logic [1:0] x);
    case (x)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Every clock advance goes through here so strobes are checked whenever enabled.
  task automatic tick();
    @(negedge clk);
    if (chk_speed && speed_valid) begin
      strobes++;
      chk("speed", speed, exp_speed);
      chk("inv speed", speed_i, -exp_speed);
      chk("inv strobe", {31'd0, speed_valid_i}, 32'd1);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!speed_valid && n < 300);
    if (!speed_valid) begin
      n_chk++;
      n_fail++;
      $display("FAIL strobe timeout: got none after %0d clk, expected one", n);
    end
  endtask

  task automatic run_steps(input int n, input bit forward);
    for (int i = 0; i < n; i++) begin
      set_ab(forward ? fwd(ab) : rev(ab));
      ticks(10);
    end
  endtask

  initial begin
    int n, exp_pos, exp_err, p0;
    logic [31:0] sp;
    logic seen;

    tbl[0]  = '{2'b10,  1, 0, 1'b1};
    tbl[1]  = '{2'b11,  1, 0, 1'b1};
    tbl[2]  = '{2'b01,  1, 0, 1'b1};
    tbl[3]  = '{2'b00,  1, 0, 1'b1};
    tbl[4]  = '{2'b01, -1, 0, 1'b0};
    tbl[5]  = '{2'b11, -1, 0, 1'b0};
    tbl[6]  = '{2'b10, -1, 0, 1'b0};
    tbl[7]  = '{2'b00, -1, 0, 1'b0};
    tbl[8]  = '{2'b11,  0, 1, 1'b0};
    tbl[9]  = '{2'b11,  0, 0, 1'b0};
    tbl[10] = '{2'b00,  0, 1, 1'b0};
    tbl[11] = '{2'b10,  1, 0, 1'b1};
    tbl[12] = '{2'b01,  0, 1, 1'b1};
    tbl[13] = '{2'b00,  1, 0, 1'b1};

    rst = 1'b1; en = 1'b1; clr_pos = 1'b0; set_ab(2'b00);
    ticks(3);
    chk("reset speed", speed, 0);
    chk("reset valid", {31'd0, speed_valid}, 0);
    chk("reset position", position, 0);
    chk("reset dir", {31'd0, dir}, 0);
    chk("reset err", {24'd0, err_cnt}, 0);
    rst = 1'b0;

    // Idle: strobes every SC clocks with zero speed.
    chk_speed = 1'b1; exp_speed = 0;
    wait_strobe(n); chk("idle first strobe interval", n, SC);
    wait_strobe(n); chk("idle strobe interval", n, SC);
    chk_speed = 1'b0;

    exp_pos = 0; exp_err = 0;
    for (int i = 0; i < 14; i++) begin
      set_ab(tbl[i].ab);
      ticks(LAT + 2);
      exp_pos += tbl[i].dpos;
      exp_err += tbl[i].derr;
      chk($sformatf("tbl[%0d] position", i), position, exp_pos);
      chk($sformatf("tbl[%0d] dir", i), {31'd0, dir}, {31'd0, tbl[i].dir});
      chk($sformatf("tbl[%0d] err", i), {24'd0, err_cnt}, exp_err);
      chk($sformatf("tbl[%0d] inv position", i), position_i, -exp_pos);
      chk($sformatf("tbl[%0d] inv dir", i), {31'd0, dir_i}, {31'd0, ~tbl[i].dir});
    end

    // Reset mid-window clears everything and suppresses the partial window.
    ticks(40);
    rst = 1'b1;
    ticks(2);
    chk("midrst position", position, 0);
    chk("midrst err", {24'd0, err_cnt}, 0);
    chk("midrst dir", {31'd0, dir}, 0);
    chk("midrst valid", {31'd0, speed_valid}, 0);
    rst = 1'b0;
    wait_strobe(n); chk("midrst strobe interval", n, SC);
    chk("midrst speed", speed, 0);

    // Forward stepping, including pin-to-position latency on the first edge.
    set_ab(fwd(ab));
    for (int i = 1; i < LAT; i++) begin
      tick();
      chk("latency early", position, 0);
    end
    tick();
    chk("latency edge", position, 1);
    ticks(10 - LAT);
    run_steps(12, 1'b1);
    strobes = 0; chk_speed = 1'b1; exp_speed = 10;
    run_steps(30, 1'b1);
    chk_speed = 1'b0;
    chk("fwd strobes seen", {31'd0, strobes >= 3}, 1);
    chk("fwd position", position, 43);
    chk("fwd dir", {31'd0, dir}, 1);
    chk("fwd inv position", position_i, -43);

    run_steps(12, 1'b0);
    strobes = 0; chk_speed = 1'b1; exp_speed = -10;
    run_steps(30, 1'b0);
    chk_speed = 1'b0;
    chk("rev strobes seen", {31'd0, strobes >= 3}, 1);
    chk("rev position", position, 1);
    chk("rev dir", {31'd0, dir}, 0);
    chk("rev inv dir", {31'd0, dir_i}, 1);

    // Illegal transitions saturate err_cnt and leave position alone.
    p0 = position;
    for (int i = 0; i < 300; i++) begin
      set_ab(ab ^ 2'b11);
      ticks(HOLD);
    end
    ticks(LAT + 2);
    chk("err saturated", {24'd0, err_cnt}, 255);
    chk("err inv saturated", {24'd0, err_cnt_i}, 255);
    chk("illegal position", position, p0);

    // Position clear and wrap in both directions.
    clr_pos = 1'b1; tick(); clr_pos = 1'b0; ticks(2);
    chk("clr position", position, 0);
    set_ab(rev(ab)); ticks(LAT + 2);
    chk("wrap down", position, 32'hFFFF_FFFF);
    set_ab(fwd(ab)); ticks(LAT + 2);
    chk("wrap up", position, 0);

    // clr_pos coinciding with the terminal count; last step lands on that edge too.
    wait_strobe(n);
    wait_strobe(n);
    chk("quiet window speed", speed, 0);
    chk_speed = 1'b1; exp_speed = 4; strobes = 0;
    for (int k = 1; k <= SC; k++) begin
      tick();
      if (k == 37 || k == 57 || k == 77 || k == SC - LAT) set_ab(fwd(ab));
      if (k == SC - 1) clr_pos = 1'b1;
      if (k == SC) clr_pos = 1'b0;
    end
    chk_speed = 1'b0;
    chk("clr+tc strobe", {31'd0, speed_valid}, 1);
    chk("clr+tc position", position, 0);
    ticks(LAT + 2);
    chk("clr+tc position after", position, 0);

    // en low mid-window: frozen, no strobe, window restarts on en rise.
    wait_strobe(n);
    sp = speed;
    p0 = position;
    ticks(30);
    en = 1'b0;
    set_ab(fwd(ab));
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (speed_valid) seen = 1'b1;
    end
    chk("en low no strobe", {31'd0, seen}, 0);
    chk("en low position", position, p0);
    chk("en low speed hold", speed, sp);
    en = 1'b1;
    wait_strobe(n); chk("en rise strobe interval", n, SC);
    chk("en rise position", position, p0);

`ifdef QEI_FILTER_EN
    p0 = position;
    set_ab(ab ^ 2'b10); ticks(5);
    set_ab(ab ^ 2'b10); ticks(20);
    chk("filter short pulse", position, p0);
    set_ab(fwd(ab));
    for (int i = 1; i < LAT; i++) tick();
    chk("filter latency early", position, p0);
    tick();
    chk("filter latency edge", position, p0 + 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
